regfile_sb: RTL

Parametrised multi-read-port integer register file with write-through bypass, a per-register busy scoreboard and a post-reset zeroing sweep. It sits between decode and writeback in the CPU pipeline. Decode reads operands and busy status here; issue marks destinations busy; writeback updates data and releases busy bits. It supersedes the fixed 2-read, 32×32 register file.

---
 rtl/regfile_sb.sv | 133 +++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port integer register file with write-through
// bypass, per-register busy scoreboard and a post-reset zeroing sweep.
// After reset the block walks every register to zero, then enters RUN and
// raises init_done. Decode reads operands and busy status combinationally.
// Issue marks destinations busy, and writeback updates data and releases busy.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRD-1:0]      re,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                issue_v,
  input  logic [AW-1:0]       issue_rd,
  input  logic                flush,
  output logic                init_done
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nx;
  logic [AW-1:0]     cnt, cnt_nx;
  logic [XLEN-1:0]   r [NREG];
  logic [NREG-1:0]   busy, busy_nx;
  logic [AW-1:0]     ra_a [NRD];
  logic              wr_ok;

  // An address names a real, writable register: inside the array and not a
  // hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // The array is only touched once the sweep is finished and the address is
  // a real register.
  assign wr_ok     = we && (state == RUN) && addr_ok(wa);
  assign init_done = (state == RUN);

  // State and sweep counter register; active-low synchronous reset restarts the sweep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Sweep sequencing: step cnt through every register, then go to RUN.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      INIT: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == AW'(NREG - 1)) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        state_nx = RUN;
      end
      default: begin
        state_nx = INIT;
        cnt_nx   = '0;
      end
    endcase
  end

  // Data array: zeroed by the sweep, written by writeback in RUN; never reset directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == INIT)
        r[cnt] <= '0;
      else if (wr_ok)
        r[wa] <= wd;
    end
  end

  // Scoreboard next value: writeback clear, then issue set, then flush; the later step wins.
  always_comb begin
    busy_nx = busy;
    if (wr_ok)
      busy_nx[wa] = 1'b0;
    if (issue_v && addr_ok(issue_rd))
      busy_nx[issue_rd] = 1'b1;
    if (flush)
      busy_nx = '0;
  end

  // Scoreboard register: cleared by reset, frozen during the sweep.
  always_ff @(posedge clk) begin
    if (!rst)
      busy <= '0;
    else if (state == RUN)
      busy <= busy_nx;
  end

  // Split the packed read-address bus into one address per port.
  always_comb begin
    for (int i = 0; i < NRD; i++)
      ra_a[i] = ra[i*AW +: AW];
  end

  // Read ports: gated to zero when idle, sweeping, or addressing a non-register;
  // a same-cycle writeback is forwarded and also satisfies a pending operand.
  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (re[i] && init_done && addr_ok(ra_a[i])) begin
        if (we && (wa == ra_a[i]))
          rd[i*XLEN +: XLEN] = wd;
        else
          rd[i*XLEN +: XLEN] = r[ra_a[i]];
      end
      if (re[i] && init_done && (int'(ra_a[i]) < NREG))
        rbusy[i] = busy[ra_a[i]] && !(we && (wa == ra_a[i]));
    end
  end

endmodule
